bcd_scan_driver: RTL and testbench

- Upstream stage of the 7-segment decoder.
- Accepts a binary value on a load strobe and converts it to NUM_DIG BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the digits onto one 4-bit BCD bus with an active-low digit-enable vector.
- bcd_out feeds the decoder's BCD input directly; an drives the display's common-anode enables.

---
 rtl/bcd_scan_driver.sv | 159 +++++++++++++++
 tb/tb_bcd_scan_driver.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_driver.sv
// bcd_scan_driver: binary -> BCD converter with a time-multiplexed digit scan.
//
// A load strobe captures bin_in. A sequential shift-add-3 (double-dabble) engine
// then converts it over BIN_W cycles. The result is committed atomically to a
// display register, which is scanned one digit at a time onto a 4-bit BCD bus.
//
// Optional build macro: BCD_SCAN_LZB_EN enables leading-zero blanking. Leading
// digits above the most-significant nonzero digit are stored as 4'hF at commit.
// Digit 0 is never blanked.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   bin_in   unsigned binary value, sampled on load while idle
//   load     capture strobe, ignored while busy
//   busy     conversion in progress (BIN_W+1 cycles)
//   ovf      committed value exceeded 10^NUM_DIG-1; all digits read 4'hF
//   bcd_out  BCD digit of the currently enabled position
//   an       active-low one-hot digit enables; bit 0 = rightmost digit
module bcd_scan_driver #(
    parameter int unsigned NUM_DIG     = 4,
    parameter int unsigned BIN_W       = 14,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BIN_W-1:0]   bin_in,
    input  logic               load,
    output logic               busy,
    output logic               ovf,
    output logic [3:0]         bcd_out,
    output logic [NUM_DIG-1:0] an
);

    localparam int unsigned SW    = 4 * NUM_DIG;
    localparam int unsigned SC_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam logic [63:0] MAX_VAL = 64'(10 ** NUM_DIG) - 64'd1;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t                    state;
    logic [BIN_W-1:0]          bin_sr;
    logic [NUM_DIG-1:0][3:0]   scr;
    logic [SC_W-1:0]           shift_cnt;
    logic                      ovf_pend;
    logic [NUM_DIG-1:0][3:0]   disp;
    logic [CNT_W-1:0]          refresh;
    logic [IDX_W-1:0]          idx;

    logic [NUM_DIG-1:0][3:0]   scr_adj;
    logic [SW-1:0]             adj_flat;
    logic [NUM_DIG-1:0][3:0]   commit_dig;
    logic [NUM_DIG-1:0][3:0]   disp_nxt;
    logic [CNT_W-1:0]          ref_nxt;
    logic [IDX_W-1:0]          idx_nxt;
    logic                      ref_tc;
`ifdef BCD_SCAN_LZB_EN
    logic                      lead;
`endif

    // Add-3 correction applied to every scratch digit before the shift
    always_comb begin
        scr_adj = scr;
        for (int i = 0; i < int'(NUM_DIG); i++) begin
            if (scr[i] >= 4'd5) begin
                scr_adj[i] = scr[i] + 4'd3;
            end
        end
        adj_flat = scr_adj;
    end

    // Value written to the display register at COMMIT
    always_comb begin
        commit_dig = scr;
`ifdef BCD_SCAN_LZB_EN
        lead = 1'b1;
        for (int i = int'(NUM_DIG) - 1; i >= 1; i--) begin
            if (scr[i] != 4'd0) begin
                lead = 1'b0;
            end
            if (lead) begin
                commit_dig[i] = 4'hF;
            end
        end
`endif
        if (ovf_pend) begin
            commit_dig = '1;
        end
    end

    // Next scan position and display contents; the output registers load from
    // these so a commit and an index change land in the same cycle
    always_comb begin
        ref_tc  = (refresh == CNT_W'(REFRESH_DIV - 1));
        ref_nxt = ref_tc ? '0 : refresh + CNT_W'(1);
        idx_nxt = idx;
        if (ref_tc) begin
            idx_nxt = (idx == IDX_W'(NUM_DIG - 1)) ? '0 : idx + IDX_W'(1);
        end
        disp_nxt = (state == COMMIT) ? commit_dig : disp;
    end

    // Conversion FSM, scan counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bin_sr    <= '0;
            scr       <= '0;
            shift_cnt <= '0;
            ovf_pend  <= 1'b0;
            disp      <= '0;
            refresh   <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            ovf       <= 1'b0;
            an        <= ~NUM_DIG'(1);
            bcd_out   <= 4'h0;
        end else begin
            refresh <= ref_nxt;
            idx     <= idx_nxt;
            disp    <= disp_nxt;
            an      <= ~(NUM_DIG'(1) << idx_nxt);
            bcd_out <= disp_nxt[idx_nxt];

            case (state)
                IDLE: begin
                    if (load) begin
                        bin_sr    <= bin_in;
                        scr       <= '0;
                        shift_cnt <= '0;
                        ovf_pend  <= (64'(bin_in) > MAX_VAL);
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Bits shifted out above the scratch width are dropped
                    scr       <= SW'({adj_flat, bin_sr[BIN_W-1]});
                    bin_sr    <= bin_sr << 1;
                    shift_cnt <= shift_cnt + SC_W'(1);
                    if (shift_cnt == SC_W'(BIN_W - 1)) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    ovf   <= ovf_pend;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Testbench for bcd_scan_driver (NUM_DIG=4, BIN_W=14, REFRESH_DIV=4).
module tb_bcd_scan_driver;

    localparam int ND = 4;
    localparam int BW = 14;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BW-1:0] bin_in = '0;
    logic          load = 1'b0;
    logic          busy;
    logic          ovf;
    logic [3:0]    bcd_out;
    logic [ND-1:0] an;

    bcd_scan_driver #(
        .NUM_DIG(ND),
        .BIN_W(BW),
        .REFRESH_DIV(RD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bin_in(bin_in),
        .load(load),
        .busy(busy),
        .ovf(ovf),
        .bcd_out(bcd_out),
        .an(an)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] bin;
        logic          ovf;
        logic [15:0]   dig;
    } vec_t;

    typedef struct {
        logic        ovf;
        logic [15:0] dig;
    } exp_t;

    vec_t vecs[10];
    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    logic [15:0] cur_disp = '0;
    logic        cur_ovf = 1'b0;

    // Expected scan position: free-running divide-by-RD, independent of loads
    int       m_cnt;
    int       m_idx;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 0;
            m_idx <= 0;
        end else if (m_cnt == RD - 1) begin
            m_cnt <= 0;
            m_idx <= (m_idx + 1) % ND;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_reset_now(input string nm);
        chk({nm, " busy"}, 32'(busy), 32'd0);
        chk({nm, " ovf"}, 32'(ovf), 32'd0);
        chk({nm, " an"}, 32'(an), 32'hE);
        chk({nm, " bcd"}, 32'(bcd_out), 32'h0);
    endtask

    // Release reset and confirm the scan holds digit 0 for exactly RD cycles
    task automatic release_and_check(input string nm);
        rst = 1'b0;
        repeat (RD - 1) tick();
        chk({nm, " an_hold"}, 32'(an), 32'hE);
        tick();
        chk({nm, " an_step"}, 32'(an), 32'hD);
    endtask

    task automatic check_display(input logic [15:0] d, input logic o, input string nm);
        logic [3:0] ea;
        chk({nm, " ovf"}, 32'(ovf), 32'(o));
        for (int c = 0; c < ND * RD; c++) begin
            ea = ~(4'b0001 << m_idx);
            chk({nm, " an"}, 32'(an), 32'(ea));
            chk({nm, " bcd"}, 32'(bcd_out), 32'(d[m_idx*4 +: 4]));
            tick();
        end
    endtask

    task automatic run_conv(input vec_t v, input bit inj, input string nm);
        exp_t e;
        int   cyc;
        e.ovf = v.ovf;
        e.dig = v.dig;
        exp_q.push_back(e);
        cyc = 0;
        while (busy !== 1'b0 && cyc < 50) begin
            tick();
            cyc++;
        end
        bin_in = v.bin;
        load = 1'b1;
        tick();
        load = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (cyc == 7) begin
                chk({nm, " hold_ovf"}, 32'(ovf), 32'(cur_ovf));
                chk({nm, " hold_bcd"}, 32'(bcd_out), 32'(cur_disp[m_idx*4 +: 4]));
            end
            if (inj && cyc == 3) begin
                bin_in = 14'd5678;
                load = 1'b1;
            end
            tick();
            load = 1'b0;
        end
        chk({nm, " busy_len"}, 32'(cyc), 32'd15);
        if (exp_q.size() == 0) begin
            chk({nm, " sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_display(e.dig, e.ovf, nm);
            cur_disp = e.dig;
            cur_ovf = e.ovf;
        end
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{bin: 14'd1234,  ovf: 1'b0, dig: 16'h1234};
        vecs[1] = '{bin: 14'd9999,  ovf: 1'b0, dig: 16'h9999};
        vecs[2] = '{bin: 14'd10000, ovf: 1'b1, dig: 16'hFFFF};
        vecs[3] = '{bin: 14'd42,    ovf: 1'b0, dig: 16'h0042};
        vecs[4] = '{bin: 14'd0,     ovf: 1'b0, dig: 16'h0000};
        vecs[5] = '{bin: 14'd16383, ovf: 1'b1, dig: 16'hFFFF};
        vecs[6] = '{bin: 14'd1005,  ovf: 1'b0, dig: 16'h1005};
        vecs[7] = '{bin: 14'd10,    ovf: 1'b0, dig: 16'h0010};
        vecs[8] = '{bin: 14'd8765,  ovf: 1'b0, dig: 16'h8765};
        vecs[9] = '{bin: 14'd7,     ovf: 1'b0, dig: 16'h0007};
`ifdef BCD_SCAN_LZB_EN
        for (int i = 0; i < 10; i++) begin
            if (!vecs[i].ovf) begin
                for (int k = 3; k >= 1; k--) begin
                    if (vecs[i].dig[k*4 +: 4] != 4'h0) break;
                    vecs[i].dig[k*4 +: 4] = 4'hF;
                end
            end
        end
`endif

        // Reset state and first scan step
        repeat (2) tick();
        check_reset_now("reset");
        release_and_check("reset");

        // Table of conversions
        for (int i = 0; i < 9; i++) begin
            run_conv(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        // Load pulse mid-conversion is ignored
        run_conv(vecs[0], 1'b1, "ign_load");

        // Reset during a conversion discards it and clears the display
        bin_in = 14'd7;
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (7) tick();
        chk("abort busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_now("abort");
        tick();
        release_and_check("abort");
        cur_disp = '0;
        cur_ovf = 1'b0;
        check_display(16'h0000, 1'b0, "abort_disp");
        v = vecs[9];
        run_conv(v, 1'b0, "reload7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule
